// File: rtl/cylon_pkg.sv
// -----------------------------------------------------------------------------
// cylon_pkg
//   Shared types and constants for the Knight-Rider LED scanner.
//   state_t : IDLE (led frozen, timer stopped) / RUN (timer running, led shifts)
//   dir_t   : LEFT (toward led[15]) / RIGHT (toward led[0])
//   CNT_W   : pulse counter width
//   LED_W   : LED bar width
//   DEFAULT_PATTERN : pattern loaded when the switches are all zero
// -----------------------------------------------------------------------------
package cylon_pkg;

   localparam int CNT_W = 28;
   localparam int LED_W = 16;

   localparam logic [LED_W-1:0] DEFAULT_PATTERN = 16'h0001;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_t;

   // An all-zero pattern would scan nothing visible, so substitute a single LED.
   function automatic logic [LED_W-1:0] load_pattern(input logic [LED_W-1:0] sw);
      return (sw == '0) ? DEFAULT_PATTERN : sw;
   endfunction

endpackage

// File: rtl/cylon_pulse_gen.sv
// -----------------------------------------------------------------------------
// cylon_pulse_gen
//   Free-running divider that produces a one-cycle tick every
//   CLOCK_CYCLES_PER_PULSE clocks while enabled.
//   Ports:
//     clk   in  system clock (rising edge)
//     rst_n in  synchronous active-low reset, clears the counter
//     en    in  count enable (scanner in RUN)
//     clr   in  restart the count from 0 (pattern load); suppresses tick
//     tick  out one-cycle pulse at terminal count
//   Parameter CLOCK_CYCLES_PER_PULSE must be >= 1; 1 ticks every enabled cycle.
// -----------------------------------------------------------------------------
module cylon_pulse_gen
   import cylon_pkg::*;
#(
   parameter logic [CNT_W-1:0] CLOCK_CYCLES_PER_PULSE = 28'd50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] TERM_CNT = CLOCK_CYCLES_PER_PULSE - 28'd1;

   logic [CNT_W-1:0] cnt_q;
   logic             at_term;

   assign at_term = (cnt_q == TERM_CNT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= at_term ? '0 : cnt_q + 28'd1;
      end
   end

   // A load in the same cycle restarts the period, so it must not also shift.
   assign tick = en & ~clr & at_term;

endmodule

// File: rtl/cylon_led_scanner.sv
// -----------------------------------------------------------------------------
// cylon_led_scanner
//   Knight-Rider style LED bar. btnC loads sw onto led and starts the scan;
//   the pattern moves one position per timer tick, bouncing off led[15] and
//   led[0]. btnL / btnR force the direction used at the next tick.
//   Ports:
//     clk   in   system clock (rising edge)
//     rst_n in   synchronous active-low reset
//     sw    in   16-bit pattern, captured on a btnC press
//     btnC  in   load/start button (active-high)
//     btnL  in   force direction LEFT  (toward led[15])
//     btnR  in   force direction RIGHT (toward led[0])
//     led   out  16-bit registered LED bar
//   Build option CYLON_SYNC_EN: adds a 2-flop synchronizer per button
//   (press-to-led latency 3 cycles instead of 2). Leave undefined only when
//   the buttons are driven synchronously to clk.
// -----------------------------------------------------------------------------
module cylon_led_scanner
   import cylon_pkg::*;
#(
   parameter logic [CNT_W-1:0] CLOCK_CYCLES_PER_PULSE = 28'd50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LED_W-1:0]  sw,
   input  logic              btnC,
   input  logic              btnL,
   input  logic              btnR,
   output logic [LED_W-1:0]  led
);

   // ---------------- button conditioning: {C, L, R} ----------------
   logic [2:0] btn_raw;
   logic [2:0] btn_cur;
   logic [2:0] btn_prev;
   logic [2:0] btn_edge;

   assign btn_raw = {btnC, btnL, btnR};

`ifdef CYLON_SYNC_EN
   logic [2:0] btn_meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_meta <= '0;
         btn_cur  <= '0;
         btn_prev <= '0;
      end else begin
         btn_meta <= btn_raw;
         btn_cur  <= btn_meta;
         btn_prev <= btn_cur;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_cur  <= '0;
         btn_prev <= '0;
      end else begin
         btn_cur  <= btn_raw;
         btn_prev <= btn_cur;
      end
   end
`endif

   assign btn_edge = btn_cur & ~btn_prev;

   logic load_evt;
   logic left_evt;
   logic right_evt;

   assign load_evt  = btn_edge[2];
   assign left_evt  = btn_edge[1];
   assign right_evt = btn_edge[0];

   // ---------------- state registers ----------------
   state_t            state_q, state_d;
   dir_t              dir_q,   dir_d;
   logic [LED_W-1:0]  led_q,   led_d;
   logic              tick;

   cylon_pulse_gen #(
      .CLOCK_CYCLES_PER_PULSE (CLOCK_CYCLES_PER_PULSE)
   ) u_pulse_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_q == RUN),
      .clr   (load_evt),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dir_q   <= LEFT;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         led_q   <= led_d;
      end
   end

   // ---------------- next state / shift logic ----------------
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      led_d   = led_q;

      if (load_evt) begin
         // Load overrides any direction press or tick in the same cycle.
         led_d   = load_pattern(sw);
         dir_d   = LEFT;
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (tick) begin
            if (led_q[LED_W-1] && led_q[0]) begin
               // Both ends lit: no legal move in either direction, hold.
               led_d = led_q;
            end else if (dir_q == LEFT) begin
               if (!led_q[LED_W-1]) begin
                  led_d = led_q << 1;
               end else begin
                  dir_d = RIGHT;
                  led_d = led_q >> 1;
               end
            end else begin
               if (!led_q[0]) begin
                  led_d = led_q >> 1;
               end else begin
                  dir_d = LEFT;
                  led_d = led_q << 1;
               end
            end
         end
         // Direction presses only retarget the next tick; both at once cancel.
         if (left_evt && !right_evt) begin
            dir_d = LEFT;
         end else if (right_evt && !left_evt) begin
            dir_d = RIGHT;
         end
      end
   end

   assign led = led_q;

endmodule

// File: tb/tb_cylon_led_scanner.sv
// -----------------------------------------------------------------------------
// tb_cylon_led_scanner
//   Directed bench for cylon_led_scanner with a 500-cycle tick period.
//   Expected LED values are pushed to a queue and popped when the bench
//   reaches the cycle at which the DUT must show them.
// -----------------------------------------------------------------------------
module tb_cylon_led_scanner;

   localparam int N = 500;
`ifdef CYLON_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] sw    = 16'h0000;
   logic        btnC  = 1'b0;
   logic        btnL  = 1'b0;
   logic        btnR  = 1'b0;
   logic [15:0] led;

   int          cyc      = 0;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   int          load_cyc = 0;
   logic [15:0] exp_q[$];

   cylon_led_scanner #(
      .CLOCK_CYCLES_PER_PULSE (28'd500)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw),
      .btnC  (btnC),
      .btnL  (btnL),
      .btnR  (btnR),
      .led   (led)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver / scoreboard tasks ----------------
   // Advance to 1 ns after rising edge number c (bounded by c itself).
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag);
      logic [15:0] e;
      e = exp_q.pop_front();
      n_checks++;
      assert (led === e) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: led=%h expected=%h", tag, led, e);
      end
   endtask

   task automatic expect_at(input int c, input logic [15:0] v, input string tag);
      exp_q.push_back(v);
      wait_until(c);
      check(tag);
   endtask

   // Press btnC for 20 cycles; checks the old value one edge before the load
   // and the loaded value on the load edge.
   task automatic load(input logic [15:0] pat, input logic [15:0] prev, input string tag);
      int s;
      @(posedge clk);
      #1;
      sw   = pat;
      btnC = 1'b1;
      s    = cyc;
      expect_at(s + LAT - 1, prev, {tag, "_preload"});
      exp_q.push_back((pat == 16'h0000) ? 16'h0001 : pat);
      wait_until(s + LAT);
      load_cyc = cyc;
      check(tag);
      wait_until(s + 20);
      btnC = 1'b0;
   endtask

   task automatic press_dir(input logic l, input logic r);
      @(posedge clk);
      #1;
      btnL = l;
      btnR = r;
      repeat (3) @(posedge clk);
      #1;
      btnL = 1'b0;
      btnR = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // 1. reset and idle
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_at(cyc, 16'h0000, "reset");
      expect_at(cyc + 1000, 16'h0000, "idle_1000");
      expect_at(cyc + 1000, 16'h0000, "idle_2000");

      // 2. scan with bounce at both ends
      load(16'h0003, 16'h0000, "t2_load");
      expect_at(load_cyc + N - 1,  16'h0003, "t2_pre_tick1");
      expect_at(load_cyc + N,      16'h0006, "t2_tick1");
      expect_at(load_cyc + 14 * N, 16'hC000, "t2_tick14");
      expect_at(load_cyc + 15 * N, 16'h6000, "t2_tick15_bounce");
      expect_at(load_cyc + 28 * N, 16'h0003, "t2_tick28");
      expect_at(load_cyc + 29 * N, 16'h0006, "t2_tick29_bounce");

      // 3. zero switches load the default pattern; reload restarts the timer
      load(16'h0000, 16'h0006, "t3_load");
      expect_at(load_cyc + N - 1, 16'h0001, "t3_pre_tick1");
      expect_at(load_cyc + N,     16'h0002, "t3_tick1");

      // 4. direction buttons
      load(16'h000C, 16'h0002, "t4_load");
      expect_at(load_cyc + 2 * N, 16'h0030, "t4_tick2");
      press_dir(1'b0, 1'b1);
      expect_at(load_cyc + 3 * N, 16'h0018, "t4_btnR");
      press_dir(1'b1, 1'b1);
      expect_at(load_cyc + 4 * N, 16'h000C, "t4_both_ignored");
      press_dir(1'b1, 1'b0);
      expect_at(load_cyc + 5 * N, 16'h0018, "t4_btnL");

      // 5. both ends lit: pattern holds
      load(16'hFFFF, 16'h0018, "t5_load");
      expect_at(load_cyc + N,      16'hFFFF, "t5_tick1");
      expect_at(load_cyc + 5 * N,  16'hFFFF, "t5_tick5");
      expect_at(load_cyc + 10 * N, 16'hFFFF, "t5_tick10");

      // 6. reset mid-scan, stays idle, then restarts cleanly
      load(16'h0001, 16'hFFFF, "t6_load");
      expect_at(load_cyc + 3 * N, 16'h0008, "t6_tick3");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      expect_at(cyc + 1, 16'h0000, "t6_reset");
      rst_n = 1'b1;
      expect_at(cyc + 1000, 16'h0000, "t6_idle_after_reset");
      load(16'h0005, 16'h0000, "t6_reload");
      expect_at(load_cyc + N, 16'h000A, "t6_reload_tick1");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
